// File: rtl/design1_wrapper_if.sv
// Bus bundles for the DAC playback engine: AXI4 write-only slave port,
// AXI-Lite register port and AXI4-Stream output.

// Handshakes: a transfer happens on a clock edge where valid && ready are both
// high; valid never waits on ready, and payload is held stable while valid && !ready.
interface axi4_wr_if #(parameter int DATA_W = 512);
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

interface axil_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

interface axis_if #(parameter int DATA_W = 512);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tvalid, input tready);
  modport slave  (input tdata, tvalid, output tready);
endinterface

// File: rtl/design1_wrapper.sv
// DAC playback engine: AXI4-loaded waveform memory streamed in a loop over [start, stop].
// Optional LOOP_CNT_EN adds a read-only pass counter at AXI-Lite bank 3, offset 0x0.
module design1_wrapper #(
    parameter int DATA_W    = 512,
    parameter int MEM_WORDS = 2048,
    parameter int PTR_W     = 17
) (
    input  logic      pl_clk,
    input  logic      pl_rst,
    axi4_wr_if.slave  s_axi,
    axil_if.slave     s_axil,
    axis_if.master    axis_0,
    output logic      dbg_stream_state
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int LSB   = $clog2(DATA_W / 8);
    localparam int NB    = DATA_W / 8;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [31:0] PTR_MASK = 32'((64'd1 << PTR_W) - 64'd1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic { S_IDLE, S_STREAM } st_t;

    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic live;

    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) live <= 1'b0;
        else        live <= 1'b1;
    end

    // ---------------- AXI4 single-beat write path ----------------
    logic              aw_held, w_held, b_valid, wr_ok;
    logic [1:0]        b_resp;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_strb;
    logic              mem_commit;

    assign s_axi.awready = live && !aw_held && !b_valid;
    assign s_axi.wready  = live && !w_held && !b_valid;
    assign s_axi.bvalid  = b_valid;
    assign s_axi.bresp   = b_resp;
    assign mem_commit    = aw_held && w_held;

    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            b_valid <= 1'b0;
            b_resp  <= OKAY;
            wr_ok   <= 1'b0;
            wr_idx  <= '0;
            wr_data <= '0;
            wr_strb <= '0;
        end else begin
            if (s_axi.awvalid && s_axi.awready) begin
                aw_held <= 1'b1;
                wr_idx  <= s_axi.awaddr[LSB+IDX_W-1:LSB];
                wr_ok   <= (s_axi.awlen == 8'd0) && (s_axi.awsize == 3'd6);
            end
            if (s_axi.wvalid && s_axi.wready) begin
                w_held  <= 1'b1;
                wr_data <= s_axi.wdata;
                wr_strb <= s_axi.wstrb;
            end
            if (mem_commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                b_valid <= 1'b1;
                b_resp  <= wr_ok ? OKAY : SLVERR;
            end else if (b_valid && s_axi.bready) begin
                b_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge pl_clk) begin
        if (mem_commit && wr_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // ---------------- AXI-Lite register bank ----------------
    logic        law_held, lw_held, lb_valid, lr_valid;
    logic [1:0]  lb_resp, lr_resp, law_bank, ar_bank;
    logic [3:0]  law_off, ar_off;
    logic [31:0] lw_data, lr_data, dac_q, start_q, stop_q, rd_word;
    logic [3:0]  lw_strb;
    logic        lw_ok, rd_err, lite_commit;
`ifdef LOOP_CNT_EN
    logic [31:0] loop_cnt;
`endif

    function automatic logic [31:0] merge_strb(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        merge_strb = old;
        for (int i = 0; i < 4; i++) if (s[i]) merge_strb[8*i +: 8] = d[8*i +: 8];
    endfunction

    assign s_axil.awready = live && !law_held && !lb_valid;
    assign s_axil.wready  = live && !lw_held && !lb_valid;
    assign s_axil.bvalid  = lb_valid;
    assign s_axil.bresp   = lb_resp;
    assign s_axil.arready = live && !lr_valid;
    assign s_axil.rvalid  = lr_valid;
    assign s_axil.rdata   = lr_data;
    assign s_axil.rresp   = lr_resp;
    assign lite_commit    = law_held && lw_held;
    assign lw_ok   = (law_bank != 2'd3) && ((law_off == 4'h0) || (law_off == 4'h4));
    assign ar_bank = s_axil.araddr[17:16];
    assign ar_off  = s_axil.araddr[3:0];

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        if (ar_off == 4'h4 && ar_bank != 2'd3) begin
            rd_word = '0;
        end else if (ar_off == 4'h0) begin
            case (ar_bank)
                2'd0:    rd_word = dac_q;
                2'd1:    rd_word = start_q;
                2'd2:    rd_word = stop_q;
`ifdef LOOP_CNT_EN
                default: rd_word = loop_cnt;
`else
                default: rd_err  = 1'b1;
`endif
            endcase
        end else begin
            rd_err = 1'b1;
        end
    end

    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            law_held <= 1'b0;
            lw_held  <= 1'b0;
            lb_valid <= 1'b0;
            lb_resp  <= OKAY;
            law_bank <= '0;
            law_off  <= '0;
            lw_data  <= '0;
            lw_strb  <= '0;
            lr_valid <= 1'b0;
            lr_data  <= '0;
            lr_resp  <= OKAY;
            dac_q    <= '0;
            start_q  <= '0;
            stop_q   <= '0;
        end else begin
            if (s_axil.awvalid && s_axil.awready) begin
                law_held <= 1'b1;
                law_bank <= s_axil.awaddr[17:16];
                law_off  <= s_axil.awaddr[3:0];
            end
            if (s_axil.wvalid && s_axil.wready) begin
                lw_held <= 1'b1;
                lw_data <= s_axil.wdata;
                lw_strb <= s_axil.wstrb;
            end
            if (lite_commit) begin
                law_held <= 1'b0;
                lw_held  <= 1'b0;
                lb_valid <= 1'b1;
                lb_resp  <= lw_ok ? OKAY : SLVERR;
                if (lw_ok && law_off == 4'h0) begin
                    case (law_bank)
                        2'd0:    dac_q   <= merge_strb(dac_q, lw_data, lw_strb) & 32'h1;
                        2'd1:    start_q <= merge_strb(start_q, lw_data, lw_strb) & PTR_MASK;
                        2'd2:    stop_q  <= merge_strb(stop_q, lw_data, lw_strb) & PTR_MASK;
                        default: ;
                    endcase
                end
            end else if (lb_valid && s_axil.bready) begin
                lb_valid <= 1'b0;
            end
            if (s_axil.arvalid && s_axil.arready) begin
                lr_valid <= 1'b1;
                lr_data  <= rd_err ? 32'h0 : rd_word;
                lr_resp  <= rd_err ? SLVERR : OKAY;
            end else if (lr_valid && s_axil.rready) begin
                lr_valid <= 1'b0;
            end
        end
    end

    // ---------------- Stream engine ----------------
    // The BRAM is read at the address the pointer will hold after this edge, so the
    // registered read data always equals mem[rd_ptr] and its latency never shows.
    st_t               st, st_nx;
    logic [IDX_W-1:0]  rd_ptr, ew_l, rd_addr;
    logic              rd_en, load_ew, fire, at_end, dac_en;
    logic [DATA_W-1:0] rd_q;

    assign dac_en           = dac_q[0];
    assign axis_0.tvalid    = (st == S_STREAM);
    assign axis_0.tdata     = rd_q;
    assign fire             = axis_0.tvalid && axis_0.tready;
    assign at_end           = (rd_ptr >= ew_l);
    assign dbg_stream_state = st;

    always_comb begin
        st_nx   = st;
        rd_en   = 1'b0;
        load_ew = 1'b0;
        rd_addr = rd_ptr;
        case (st)
            S_IDLE: begin
                if (dac_en) begin
                    st_nx   = S_STREAM;
                    rd_en   = 1'b1;
                    load_ew = 1'b1;
                    rd_addr = start_q[LSB+IDX_W-1:LSB];
                end
            end
            default: begin
                if (!dac_en) begin
                    st_nx = S_IDLE;
                end else if (fire) begin
                    rd_en   = 1'b1;
                    load_ew = at_end;
                    rd_addr = at_end ? start_q[LSB+IDX_W-1:LSB] : rd_ptr + IDX_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            st     <= S_IDLE;
            rd_ptr <= '0;
            ew_l   <= '0;
            rd_q   <= '0;
        end else begin
            st <= st_nx;
            if (rd_en) begin
                rd_ptr <= rd_addr;
                rd_q   <= mem[rd_addr];
            end
            if (load_ew) ew_l <= stop_q[LSB+IDX_W-1:LSB];
        end
    end

`ifdef LOOP_CNT_EN
    always_ff @(posedge pl_clk or posedge pl_rst) begin
        if (pl_rst) begin
            loop_cnt <= '0;
        end else if (st == S_IDLE && dac_en) begin
            loop_cnt <= '0;
        end else if (fire && dac_en && at_end && loop_cnt != 32'hFFFF_FFFF) begin
            loop_cnt <= loop_cnt + 32'd1;
        end
    end
`endif

    wire unused_ok = &{1'b0, s_axi.awaddr[31:LSB+IDX_W], s_axi.awaddr[LSB-1:0], s_axi.awburst,
                       s_axi.wlast, s_axil.awaddr[31:18], s_axil.awaddr[15:4],
                       s_axil.araddr[31:18], s_axil.araddr[15:4]};
endmodule

// File: tb/tb_design1_wrapper.sv
// Directed bench for the DAC playback engine: register map, memory load,
// looping stream with stalls, window changes, disable and reset mid-stream.
module tb_design1_wrapper;
    localparam int LIMIT = 20;

    logic pl_clk = 1'b0;
    logic pl_rst;
    logic dbg_stream_state;
    always #5 pl_clk = ~pl_clk;

    axi4_wr_if s_axi ();
    axil_if    s_axil ();
    axis_if    axis_0 ();

    design1_wrapper dut (
        .pl_clk          (pl_clk),
        .pl_rst          (pl_rst),
        .s_axi           (s_axi),
        .s_axil          (s_axil),
        .axis_0          (axis_0),
        .dbg_stream_state(dbg_stream_state)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [511:0] exp_q[$];
    logic [511:0] model [2048];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int w);
        logic [7:0] b;
        b = w[7:0];
        return {64{b}};
    endfunction

    task automatic tick();
        @(posedge pl_clk);
        #1;
    endtask

    // ---- driver tasks ----
    task automatic axil_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        int cyc;
        logic a, w;
        s_axil.awaddr = addr; s_axil.awvalid = 1'b1;
        s_axil.wdata = data; s_axil.wstrb = 4'hF; s_axil.wvalid = 1'b1;
        cyc = 0;
        while ((s_axil.awvalid || s_axil.wvalid) && cyc < LIMIT) begin
            a = s_axil.awready; w = s_axil.wready;
            tick();
            if (a) s_axil.awvalid = 1'b0;
            if (w) s_axil.wvalid = 1'b0;
            cyc++;
        end
        check("axil_wr_handshake_timeout", cyc < LIMIT, 1'b1);
        s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
        s_axil.bready = 1'b1;
        cyc = 0;
        while (!s_axil.bvalid && cyc < LIMIT) begin tick(); cyc++; end
        check("axil_bvalid_timeout", cyc < LIMIT, 1'b1);
        resp = s_axil.bresp;
        tick();
        s_axil.bready = 1'b0;
    endtask

    task automatic axil_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        logic a;
        s_axil.araddr = addr; s_axil.arvalid = 1'b1;
        cyc = 0;
        while (s_axil.arvalid && cyc < LIMIT) begin
            a = s_axil.arready;
            tick();
            if (a) s_axil.arvalid = 1'b0;
            cyc++;
        end
        check("axil_ar_timeout", cyc < LIMIT, 1'b1);
        s_axil.arvalid = 1'b0;
        s_axil.rready = 1'b1;
        cyc = 0;
        while (!s_axil.rvalid && cyc < LIMIT) begin tick(); cyc++; end
        check("axil_rvalid_timeout", cyc < LIMIT, 1'b1);
        data = s_axil.rdata; resp = s_axil.rresp;
        tick();
        s_axil.rready = 1'b0;
    endtask

    task automatic axi_write(input int idx, input logic [511:0] data, input logic [63:0] strb,
                             input logic [7:0] len, input logic [2:0] size, output logic [1:0] resp);
        int cyc;
        logic a, w;
        s_axi.awaddr = 32'hC000_0000 + 32'(idx) * 32'd64;
        s_axi.awlen = len; s_axi.awsize = size; s_axi.awburst = 2'b01; s_axi.awvalid = 1'b1;
        s_axi.wdata = data; s_axi.wstrb = strb; s_axi.wlast = 1'b1; s_axi.wvalid = 1'b1;
        cyc = 0;
        while ((s_axi.awvalid || s_axi.wvalid) && cyc < LIMIT) begin
            a = s_axi.awready; w = s_axi.wready;
            tick();
            if (a) s_axi.awvalid = 1'b0;
            if (w) s_axi.wvalid = 1'b0;
            cyc++;
        end
        check("axi_wr_handshake_timeout", cyc < LIMIT, 1'b1);
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b1;
        cyc = 0;
        while (!s_axi.bvalid && cyc < LIMIT) begin tick(); cyc++; end
        check("axi_bvalid_timeout", cyc < LIMIT, 1'b1);
        resp = s_axi.bresp;
        tick();
        s_axi.bready = 1'b0;
    endtask

    task automatic wait_tvalid();
        int cyc;
        cyc = 0;
        while (!axis_0.tvalid && cyc < 3) begin tick(); cyc++; end
        check("tvalid_rise_latency", axis_0.tvalid, 1'b1);
    endtask

    // ---- directed sequence ----
    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [511:0] prev, tmp;
        logic stalled;
        logic [31:0] rst_addrs [4];

        rst_addrs = '{32'h4000_0000, 32'h4001_0000, 32'h4002_0000, 32'h4001_0004};
        s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0; s_axi.awburst = '0;
        s_axi.awvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0;
        s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axil.awaddr = '0; s_axil.awvalid = 1'b0; s_axil.wdata = '0; s_axil.wstrb = '0;
        s_axil.wvalid = 1'b0; s_axil.bready = 1'b0; s_axil.araddr = '0; s_axil.arvalid = 1'b0;
        s_axil.rready = 1'b0;
        axis_0.tready = 1'b0;

        pl_rst = 1'b1;
        repeat (3) tick();
        check("rst_awready", s_axi.awready, 1'b0);
        check("rst_wready", s_axi.wready, 1'b0);
        check("rst_bvalid", s_axi.bvalid, 1'b0);
        check("rst_lite_arready", s_axil.arready, 1'b0);
        check("rst_lite_bvalid", s_axil.bvalid, 1'b0);
        check("rst_lite_rvalid", s_axil.rvalid, 1'b0);
        check("rst_tvalid", axis_0.tvalid, 1'b0);
        check("rst_tdata", axis_0.tdata, 512'h0);
        check("rst_dbg_state", dbg_stream_state, 1'b0);
        pl_rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 4; i++) begin
            axil_read(rst_addrs[i], rd, rs);
            check($sformatf("rst_read_data_%0d", i), rd, 32'h0);
            check($sformatf("rst_read_resp_%0d", i), rs, 2'b00);
        end

        // register map, masking and error decode
        axil_write(32'h4001_0000, 32'h0000_0000, rs); check("wr_start_resp", rs, 2'b00);
        axil_write(32'h4002_0000, 32'h0000_0C00, rs); check("wr_stop_resp", rs, 2'b00);
        axil_read(32'h4001_0000, rd, rs); check("rd_start", rd, 32'h0); check("rd_start_resp", rs, 2'b00);
        axil_read(32'h4002_0000, rd, rs); check("rd_stop", rd, 32'h0000_0C00); check("rd_stop_resp", rs, 2'b00);
        axil_write(32'h4000_0000, 32'hFFFF_FFFE, rs); check("wr_dac_mask_resp", rs, 2'b00);
        axil_read(32'h4000_0000, rd, rs); check("rd_dac_mask", rd, 32'h0);
        axil_write(32'h4001_0000, 32'hFFFF_FFFF, rs);
        axil_read(32'h4001_0000, rd, rs); check("rd_start_mask", rd, 32'h0001_FFFF);
        axil_write(32'h4001_0000, 32'h0000_0000, rs);
        axil_write(32'h4001_0004, 32'h0000_1234, rs); check("wr_tri_resp", rs, 2'b00);
        axil_read(32'h4001_0004, rd, rs); check("rd_tri", rd, 32'h0);
        axil_write(32'h4003_0000, 32'h0000_0001, rs); check("wr_bank3_resp", rs, 2'b10);
        axil_write(32'h4000_0008, 32'h0000_0001, rs); check("wr_badoff_resp", rs, 2'b10);
        axil_read(32'h4000_0008, rd, rs); check("rd_badoff_data", rd, 32'h0); check("rd_badoff_resp", rs, 2'b10);
        axil_read(32'h4000_0000, rd, rs); check("rd_dac_after_bad", rd, 32'h0);

        // waveform memory load
        for (int w = 0; w < 2048; w++) begin
            model[w] = pat(w);
            axi_write(w, pat(w), {64{1'b1}}, 8'd0, 3'd6, rs);
            check($sformatf("axi_bresp_w%0d", w), rs, 2'b00);
        end
        axi_write(5, {512{1'b1}}, {64{1'b1}}, 8'd1, 3'd6, rs); check("axi_awlen1_slverr", rs, 2'b10);
        axi_write(6, {512{1'b1}}, {64{1'b1}}, 8'd0, 3'd3, rs); check("axi_awsize3_slverr", rs, 2'b10);
        axi_write(10, {64{8'hAA}}, 64'h1, 8'd0, 3'd6, rs); check("axi_strb_resp", rs, 2'b00);
        model[10][7:0] = 8'hAA;

        // enable: window 0..48 looping
        for (int i = 0; i < 600; i++) exp_q.push_back(model[i % 49]);
        axil_write(32'h4000_0000, 32'h1, rs); check("wr_dac_en_resp", rs, 2'b00);
        wait_tvalid();
        check("dbg_state_stream", dbg_stream_state, 1'b1);
        axis_0.tready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            check($sformatf("beat%0d_tvalid", i), axis_0.tvalid, 1'b1);
            check($sformatf("beat%0d_tdata", i), axis_0.tdata, exp_q[0]);
            tick();
            void'(exp_q.pop_front());
        end

        // random backpressure
        stalled = 1'b0;
        prev = '0;
        for (int i = 0; i < 200; i++) begin
            axis_0.tready = 1'($urandom_range(0, 1));
            check("stall_tvalid", axis_0.tvalid, 1'b1);
            if (stalled) check("stall_tdata_stable", axis_0.tdata, prev);
            check($sformatf("rand_tdata_%0d", i), axis_0.tdata, exp_q[0]);
            prev = axis_0.tdata;
            stalled = !axis_0.tready;
            tick();
            if (!stalled) void'(exp_q.pop_front());
        end

        // disable mid-stream
        axis_0.tready = 1'b1;
        axil_write(32'h4000_0000, 32'h0, rs);
        check("dis_tvalid_next", axis_0.tvalid, 1'b0);
        tick();
        check("dis_tvalid_hold", axis_0.tvalid, 1'b0);

        // start beyond stop: single word at sw repeats
        axis_0.tready = 1'b0;
        axil_write(32'h4001_0000, 32'h0000_1000, rs);
        axil_write(32'h4000_0000, 32'h1, rs);
        wait_tvalid();
        axis_0.tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("single_word_%0d", i), axis_0.tdata, model[64]);
            check("single_word_tvalid", axis_0.tvalid, 1'b1);
            tick();
        end

        // re-enable restarts at new sw; covers rejected and strobed writes
        axil_write(32'h4000_0000, 32'h0, rs);
        axis_0.tready = 1'b0;
        axil_write(32'h4001_0000, 32'h0000_0080, rs);
        axil_write(32'h4000_0000, 32'h1, rs);
        wait_tvalid();
        axis_0.tready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            check($sformatf("restart_word_%0d", i), axis_0.tdata, model[i]);
            tick();
        end
        tmp = pat(10);
        tmp[7:0] = 8'hAA;
        check("model_strobe_word", model[10], tmp);

        // asynchronous reset mid-stream
        check("pre_rst_tvalid", axis_0.tvalid, 1'b1);
        pl_rst = 1'b1;
        #1;
        check("async_rst_tvalid", axis_0.tvalid, 1'b0);
        check("async_rst_tdata", axis_0.tdata, 512'h0);
        tick();
        pl_rst = 1'b0;
        repeat (3) tick();
        check("post_rst_tvalid", axis_0.tvalid, 1'b0);
        axil_read(32'h4000_0000, rd, rs); check("post_rst_dac", rd, 32'h0);
        axil_read(32'h4001_0000, rd, rs); check("post_rst_start", rd, 32'h0);
        axil_read(32'h4003_0000, rd, rs);
        check("post_rst_bank3_data", rd, 32'h0);
`ifdef LOOP_CNT_EN
        check("post_rst_bank3_resp", rs, 2'b00);
`else
        check("post_rst_bank3_resp", rs, 2'b10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
